cosine_series: RTL
==================

COSINE_SERIES -- requirements
Module: cosine_series

Interface
REQ-001 SHALL have parameter TERMS, default 5, meaning the number of Taylor terms including the constant 1.0; legal range 2..5.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin one evaluation.
REQ-005 SHALL have port x, input, 16 bits: angle in radians, signed Q5.11 two's complement.
REQ-006 SHALL have port busy, output, 1 bit: high while an evaluation is in progress.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse, result just updated.
REQ-008 SHALL have port result, output, 16 bits: cos(x), signed Q5.11.

Function
REQ-009 SHALL use a state machine with states IDLE, REDUCE (macro only), SQUARE, MULX, MULR and DONE.
REQ-010 SHALL sample start only in IDLE; on start=1, capture x into an internal register and leave IDLE.
REQ-011 SHALL ignore start in every state other than IDLE, with no queueing.
REQ-012 SHALL perform every multiply with the team Q5.11 rule: take operand magnitudes; result magnitude is product bits [26:11] (truncate, wrap on overflow); negate if the operand signs differ.
REQ-013 SHALL compute x2 = x*x in SQUARE (1 cycle), and initialise term=2048 and acc=2048 at the same time.
REQ-014 SHALL execute, for k=1..TERMS-1, the following two cycles:
- MULX: term = term*x2.
- MULR: term = term*R[k], then acc = acc - term for odd k and acc = acc + term for even k.
REQ-015 SHALL use constants R[1..4] = 1024, 171, 68, 37 (1/2, 1/12, 1/30, 1/56 in Q5.11).
REQ-016 SHALL saturate the accumulator add/subtract to the range 0x8000..0x7FFF instead of wrapping.
REQ-017 SHALL, after the last MULR, load result from acc and enter DONE.
REQ-018 SHALL assert done only in DONE, for exactly one cycle, then return to IDLE.
REQ-019 SHALL keep busy high in REDUCE/SQUARE/MULX/MULR and low in IDLE and DONE.
REQ-020 SHALL hold result unchanged from one DONE until the next DONE.
REQ-021 SHALL reach DONE 2*TERMS-1 edges after the start-sampling edge when the macro is absent (9 edges for TERMS=5); done is high in the following cycle.
REQ-022 SHALL allow a new start in the IDLE cycle immediately after DONE; back-to-back evaluations are legal.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, force state to IDLE and busy=0, done=0, result=0x0000, and clear all internal registers, regardless of the current state.
REQ-024 SHALL give rst priority over start when both are high; a reset mid-evaluation discards that evaluation and produces no done pulse.

Configuration
REQ-025 SHALL compile range reduction in only when macro COSINE_RANGE_REDUCE_EN is defined.
REQ-026 SHALL, with the macro defined, apply the following in IDLE on start:
- if captured x > 6434 (pi) or x < -6434, enter REDUCE; otherwise go directly to SQUARE.
- REDUCE subtracts 12868 (2*pi) if x > 6434, else adds 12868; one adjustment per cycle.
- REDUCE exits to SQUARE once -6434 <= x <= 6434.
- latency grows by 1 cycle per adjustment, at most 3 adjustments.
REQ-027 SHALL, without the macro, have no REDUCE state and use x unmodified.

Verification
REQ-028 SHALL cover reset: rst=1 for 2 cycles, then idle -> busy=0, done=0, result=0x0000.
REQ-029 SHALL cover x=0x0000, TERMS=5, start pulse -> done high exactly once, 9 edges after start is sampled, result=0x0800.
REQ-030 SHALL cover x=0x0800 (1.0), then x=0xF800 (-1.0) back-to-back -> both give result=0x0453 (1107).
REQ-031 SHALL cover start held high during an evaluation with x changed mid-run -> result still 0x0453 for the original x=0x0800; the second request is not queued.
REQ-032 SHALL cover rst asserted in the 4th cycle of an evaluation -> no done pulse, result=0x0000, and the next start completes normally.
REQ-033 SHALL cover, with COSINE_RANGE_REDUCE_EN defined, x=0x2000 (4.0) -> one REDUCE cycle, done 10 edges after start, and result equal to the result for x=-4676 without the macro.

Source files
------------

// File: rtl/cosine_series.sv
// ----------------------------------------------------------------------------
// cosine_series
//   Iterative cos(x) evaluator using a truncated Taylor series in signed Q5.11.
//   One evaluation is started from IDLE. It squares x once and then runs
//   TERMS-1 pairs of multiply cycles. Each pair updates the running term and
//   adds it to, or subtracts it from, a saturating accumulator.
//
//   Parameters
//     TERMS   number of Taylor terms including the constant 1.0 (2..5)
//
//   Ports
//     clk     clock, all state changes on the rising edge
//     rst     synchronous active-high reset
//     start   begin an evaluation (sampled only while idle)
//     x       angle in radians, signed Q5.11
//     busy    high while an evaluation is running
//     done    one-cycle pulse when result has just been updated
//     result  cos(x), signed Q5.11, held until the next done
//
//   Optional feature
//     COSINE_RANGE_REDUCE_EN  when defined, angles outside [-pi, pi] are first
//                             folded into that range, one 2*pi step per cycle.
// ----------------------------------------------------------------------------
module cosine_series #(
    parameter int TERMS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] x,
    output logic        busy,
    output logic        done,
    output logic [15:0] result
);

`ifdef COSINE_RANGE_REDUCE_EN
    typedef enum logic [2:0] {IDLE, REDUCE, SQUARE, MULX, MULR, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, SQUARE, MULX, MULR, DONE} state_t;
`endif

    localparam logic [15:0] ONE_Q = 16'd2048;
    localparam logic [2:0]  LAST_K = 3'(TERMS - 1);

    state_t      state_reg, state_next;
    logic [15:0] x_reg;
    logic [15:0] x2_reg;
    logic [15:0] term_reg;
    logic [15:0] acc_reg;
    logic [15:0] result_reg;
    logic [2:0]  k_reg;

    logic [15:0] term_x;
    logic [15:0] term_r;
    logic [15:0] acc_sum;
    logic        last_k;

    // Sign-magnitude Q5.11 multiply. The magnitude keeps product bits [26:11]
    // (truncated, wraps on overflow), then the sign is re-applied.
    function automatic logic [15:0] q_mul(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] ma;
        logic [15:0] mb;
        logic [31:0] p;
        logic [15:0] m;
        ma = a[15] ? (~a + 16'd1) : a;
        mb = b[15] ? (~b + 16'd1) : b;
        p  = {16'd0, ma} * {16'd0, mb};
        p  = p >> 11;
        m  = p[15:0];
        return (a[15] ^ b[15]) ? (~m + 16'd1) : m;
    endfunction

    // Saturating signed add/subtract into the 16-bit accumulator range.
    function automatic logic [15:0] sat_addsub(input logic [15:0] a, input logic [15:0] b,
                                               input logic sub);
        logic [16:0] s;
        s = sub ? ({a[15], a} - {b[15], b}) : ({a[15], a} + {b[15], b});
        if (s[16] != s[15]) begin
            return s[16] ? 16'h8000 : 16'h7FFF;
        end
        return s[15:0];
    endfunction

    // Reciprocal factors 1/((2k-1)(2k)) for each series step.
    function automatic logic [15:0] r_const(input logic [2:0] k);
        case (k)
            3'd1:    return 16'd1024;
            3'd2:    return 16'd171;
            3'd3:    return 16'd68;
            3'd4:    return 16'd37;
            default: return 16'd0;
        endcase
    endfunction

`ifdef COSINE_RANGE_REDUCE_EN
    function automatic logic out_of_range(input logic [15:0] v);
        return ($signed(v) > 16'sd6434) || ($signed(v) < -16'sd6434);
    endfunction

    logic [15:0] x_adj;
    // One 2*pi fold toward zero.
    assign x_adj = ($signed(x_reg) > 16'sd6434) ? (x_reg - 16'd12868) : (x_reg + 16'd12868);
`endif

    assign term_x  = q_mul(term_reg, x2_reg);
    assign term_r  = q_mul(term_reg, r_const(k_reg));
    // Odd steps subtract, even steps add (alternating Taylor signs).
    assign acc_sum = sat_addsub(acc_reg, term_r, k_reg[0]);
    assign last_k  = (k_reg == LAST_K);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
`ifdef COSINE_RANGE_REDUCE_EN
                    state_next = out_of_range(x) ? REDUCE : SQUARE;
`else
                    state_next = SQUARE;
`endif
                end
            end
`ifdef COSINE_RANGE_REDUCE_EN
            REDUCE: begin
                if (!out_of_range(x_adj)) begin
                    state_next = SQUARE;
                end
            end
`endif
            SQUARE:  state_next = MULX;
            MULX:    state_next = MULR;
            MULR:    state_next = last_k ? DONE : MULX;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            x_reg      <= 16'd0;
            x2_reg     <= 16'd0;
            term_reg   <= 16'd0;
            acc_reg    <= 16'd0;
            result_reg <= 16'd0;
            k_reg      <= 3'd0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        x_reg <= x;
                    end
                end
`ifdef COSINE_RANGE_REDUCE_EN
                REDUCE: begin
                    x_reg <= x_adj;
                end
`endif
                SQUARE: begin
                    x2_reg   <= q_mul(x_reg, x_reg);
                    term_reg <= ONE_Q;
                    acc_reg  <= ONE_Q;
                    k_reg    <= 3'd1;
                end
                MULX: begin
                    term_reg <= term_x;
                end
                MULR: begin
                    term_reg <= term_r;
                    acc_reg  <= acc_sum;
                    if (last_k) begin
                        result_reg <= acc_sum;
                    end else begin
                        k_reg <= k_reg + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (state_reg != IDLE) && (state_reg != DONE);
    assign done   = (state_reg == DONE);
    assign result = result_reg;

endmodule
